// File: rtl/sos_pkg.sv
// sos_pkg: shared definitions for the sum-of-sinusoids noise generator.
//   - state_e     : sequencer FSM encoding
//   - clog2       : ceiling log2, used for tone-index and output widths
//   - lut_quarter : LUT address of the quarter-period point (cos = 0)
//   - lut_half    : LUT address of the half-period point (cos = -full scale)
//   - full_scale  : largest positive LUT magnitude, 2^(DATA_W-1)-1
package sos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int lut_quarter(input int aw);
        return 1 << (aw - 2);
    endfunction

    function automatic int lut_half(input int aw);
        return 1 << (aw - 1);
    endfunction

    // Symmetric full scale: the most negative code is never produced, so
    // negating a LUT value can never overflow.
    function automatic int full_scale(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

endpackage

// File: rtl/sos_cos_lut.sv
// sos_cos_lut: dual-read registered cosine ROM, 1-cycle latency.
// Only the first quarter wave (0..pi/2 inclusive) is stored; the other
// quadrants are folded onto it by mirroring the address and negating.
//   clk_i             clock
//   addr_i_i/addr_q_i phase addresses (LUT_AW bits, full period)
//   cos_i_o/cos_q_o   signed cosine samples, DATA_W bits, registered
module sos_cos_lut
    import sos_pkg::*;
#(
    parameter int LUT_AW = 10,
    parameter int DATA_W = 16
) (
    input  logic                     clk_i,
    input  logic [LUT_AW-1:0]        addr_i_i,
    input  logic [LUT_AW-1:0]        addr_q_i,
    output logic signed [DATA_W-1:0] cos_i_o,
    output logic signed [DATA_W-1:0] cos_q_o
);

    localparam int QN = lut_quarter(LUT_AW);

    // Table generator, evaluated at elaboration only. The two end points are
    // forced so the zero crossings and the peak are exact.
    function automatic logic signed [DATA_W-1:0] qval(input int a);
        real x;
        if (a == 0) return DATA_W'(full_scale(DATA_W));
        if (a >= QN) return '0;
        x = $itor(full_scale(DATA_W)) *
            $cos(3.141592653589793 * $itor(a) / $itor(2 * QN));
        return DATA_W'($rtoi(x + 0.5));
    endfunction

    logic signed [DATA_W-1:0] qrom [QN+1];

    for (genvar a = 0; a <= QN; a++) begin : g_rom
        assign qrom[a] = qval(a);
    end

    logic [1:0][LUT_AW-1:0] addr;
    assign addr = {addr_q_i, addr_i_i};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [LUT_AW-2:0]        idx;
        logic signed [DATA_W-1:0] mag;
        logic signed [DATA_W-1:0] val_q;

        // Quadrants 1 and 3 run the quarter table backwards; quadrants 1 and
        // 2 are negative.
        always_comb begin
            idx = {1'b0, addr[p][LUT_AW-3:0]};
            if (addr[p][LUT_AW-2]) idx = (LUT_AW-1)'(QN) - idx;
            mag = qrom[idx];
        end

        always_ff @(posedge clk_i) begin
            val_q <= (addr[p][LUT_AW-1] ^ addr[p][LUT_AW-2]) ? -mag : mag;
        end
    end

    assign cos_i_o = g_port[0].val_q;
    assign cos_q_o = g_port[1].val_q;

endmodule

// File: rtl/sos_noise_gen.sv
// sos_noise_gen: time-multiplexed sum-of-sinusoids Gaussian noise source.
// On each accepted request, N_TONES tones per branch are walked one per
// cycle through a shared cosine LUT and summed; the sums are scaled by an
// arithmetic right shift and presented with a one-cycle out_valid pulse.
//   clk_fs, rst        sample clock, async active-high reset
//   req / req_ready    request handshake (ready only in IDLE)
//   omega_n_add        frequency offset added to every tone step
//   gain_shift         arithmetic right shift of the sums
//   cfg_we/q/idx/freq  frequency table write port; cfg_err flags drops
//   gauss_I/Q          signed noise samples, out_valid strobe
module sos_noise_gen
    import sos_pkg::*;
#(
    parameter int N_TONES = 16,
    parameter int FREQ_W  = 14,
    parameter int LUT_AW  = 10,
    parameter int DATA_W  = 16
) (
    input  logic                                        clk_fs,
    input  logic                                        rst,
    input  logic                                        req,
    output logic                                        req_ready,
    input  logic [FREQ_W-1:0]                           omega_n_add,
    input  logic [3:0]                                  gain_shift,
    input  logic                                        cfg_we,
    input  logic                                        cfg_q,
    input  logic [clog2(N_TONES)-1:0]                   cfg_idx,
    input  logic [FREQ_W-1:0]                           cfg_freq,
    output logic                                        cfg_err,
    output logic signed [DATA_W+clog2(N_TONES)-1:0]     gauss_I,
    output logic signed [DATA_W+clog2(N_TONES)-1:0]     gauss_Q,
    output logic                                        out_valid
);

    localparam int IDX_W = clog2(N_TONES);
    localparam int OUT_W = DATA_W + IDX_W;

    state_e                   state_q;
    logic [IDX_W-1:0]         k_q;
    logic                     vld_q;      // LUT output holds a tone to add
    logic [FREQ_W-1:0]        phase_i_q [N_TONES];
    logic [FREQ_W-1:0]        phase_q_q [N_TONES];
    logic [FREQ_W-1:0]        freq_i_q  [N_TONES];
    logic [FREQ_W-1:0]        freq_q_q  [N_TONES];
    logic signed [OUT_W-1:0]  acc_i_q, acc_q_q;
    logic signed [OUT_W-1:0]  gauss_i_q, gauss_q_q;
    logic                     out_valid_q, cfg_err_q, ready_q;
    logic signed [DATA_W-1:0] cos_i, cos_q;

    // Pre-update phase of the current tone addresses the LUT.
    sos_cos_lut #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_lut (
        .clk_i    (clk_fs),
        .addr_i_i (phase_i_q[k_q][FREQ_W-1 -: LUT_AW]),
        .addr_q_i (phase_q_q[k_q][FREQ_W-1 -: LUT_AW]),
        .cos_i_o  (cos_i),
        .cos_q_o  (cos_q)
    );

    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            vld_q       <= 1'b0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            gauss_i_q   <= '0;
            gauss_q_q   <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            ready_q     <= 1'b1;
            for (int i = 0; i < N_TONES; i++) begin
                phase_i_q[i] <= '0;
                phase_q_q[i] <= '0;
                freq_i_q[i]  <= '0;
                freq_q_q[i]  <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            vld_q       <= (state_q == ST_RUN);

            if (vld_q) begin
                acc_i_q <= acc_i_q + OUT_W'(cos_i);
                acc_q_q <= acc_q_q + OUT_W'(cos_q);
            end

            // Table writes only land while idle, including the acceptance
            // cycle, so a request never sees a half-updated table.
            if (cfg_we) begin
                if (state_q == ST_IDLE) begin
                    if (cfg_q) freq_q_q[cfg_idx] <= cfg_freq;
                    else       freq_i_q[cfg_idx] <= cfg_freq;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= ST_RUN;
                        k_q     <= '0;
                        acc_i_q <= '0;
                        acc_q_q <= '0;
                        ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    phase_i_q[k_q] <= phase_i_q[k_q] + freq_i_q[k_q] + omega_n_add;
                    phase_q_q[k_q] <= phase_q_q[k_q] + freq_q_q[k_q] + omega_n_add;
                    k_q            <= k_q + 1'b1;
                    if (k_q == IDX_W'(N_TONES - 1)) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Last tone is added on the edge where vld_q drops.
                    if (!vld_q) begin
                        state_q     <= ST_IDLE;
                        ready_q     <= 1'b1;
                        out_valid_q <= 1'b1;
                        gauss_i_q   <= acc_i_q >>> gain_shift;
                        gauss_q_q   <= acc_q_q >>> gain_shift;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign gauss_I   = gauss_i_q;
    assign gauss_Q   = gauss_q_q;

endmodule

// File: tb/tb_sos_noise_gen.sv
module tb_sos_noise_gen;

    localparam int OUT_W = 20;
    localparam logic signed [OUT_W-1:0] FS16 = 20'sd524272;

    typedef struct {
        logic signed [OUT_W-1:0] i;
        logic signed [OUT_W-1:0] q;
    } exp_t;

    logic                    clk_fs = 1'b0;
    logic                    rst = 1'b1;
    logic                    req = 1'b0;
    logic                    req_ready;
    logic [13:0]             omega_n_add = '0;
    logic [3:0]              gain_shift = '0;
    logic                    cfg_we = 1'b0;
    logic                    cfg_q = 1'b0;
    logic [3:0]              cfg_idx = '0;
    logic [13:0]             cfg_freq = '0;
    logic                    cfg_err;
    logic signed [OUT_W-1:0] gauss_I, gauss_Q;
    logic                    out_valid;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    sos_noise_gen dut (
        .clk_fs(clk_fs), .rst(rst), .req(req), .req_ready(req_ready),
        .omega_n_add(omega_n_add), .gain_shift(gain_shift),
        .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_idx(cfg_idx), .cfg_freq(cfg_freq),
        .cfg_err(cfg_err), .gauss_I(gauss_I), .gauss_Q(gauss_Q),
        .out_valid(out_valid)
    );

    always #5 clk_fs = ~clk_fs;

    task automatic do_reset();
        @(negedge clk_fs) rst = 1'b1;
        repeat (2) @(posedge clk_fs);
        @(negedge clk_fs) rst = 1'b0;
    endtask

    task automatic cfg_write(input logic q, input logic [3:0] idx, input logic [13:0] f);
        @(negedge clk_fs);
        cfg_we = 1'b1; cfg_q = q; cfg_idx = idx; cfg_freq = f;
        @(negedge clk_fs);
        cfg_we = 1'b0;
    endtask

    // Issues one request and waits (bounded) for out_valid. lat = 0 on timeout.
    task automatic run_sample(output logic signed [OUT_W-1:0] gi, output logic signed [OUT_W-1:0] gq,
                              output int lat, output bit rdy_ok);
        @(negedge clk_fs) req = 1'b1;
        @(posedge clk_fs);
        #1 req = 1'b0;
        lat = 0; rdy_ok = 1'b1; gi = '0; gq = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_fs);
            #1;
            if (out_valid) begin
                lat = n; gi = gauss_I; gq = gauss_Q;
                if (!req_ready) rdy_ok = 1'b0;
                break;
            end else if (req_ready) begin
                rdy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk_fs);
        checks++;
        if (gauss_I !== 0 || gauss_Q !== 0) begin
            failures++;
            $display("FAIL reset_gauss got I=%0d Q=%0d want 0", gauss_I, gauss_Q);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes got valid=%b err=%b want 0 0", out_valid, cfg_err);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic signed [OUT_W-1:0] gi, gq;
        int lat; bit rdy_ok; exp_t e;
        do_reset();
        repeat (3) sb.push_back('{FS16, FS16});
        for (int s = 0; s < 3; s++) begin
            run_sample(gi, gq, lat, rdy_ok);
            e = sb.pop_front();
            checks++;
            if (gi !== e.i || gq !== e.q) begin
                failures++;
                $display("FAIL b2b_value[%0d] got I=%0d Q=%0d want I=%0d Q=%0d", s, gi, gq, e.i, e.q);
            end
            checks++;
            if (lat !== 18) begin
                failures++;
                $display("FAIL b2b_latency[%0d] got %0d want 18", s, lat);
            end
            checks++;
            if (!rdy_ok) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got ready high early or low at out_valid want low 18 cycles", s);
            end
        end
    endtask

    task automatic test_freq_table();
        logic signed [OUT_W-1:0] gi, gq;
        int lat; bit rdy_ok; exp_t e;
        do_reset();
        cfg_write(1'b0, 4'd0, 14'h2000);
        sb.push_back('{FS16, FS16});
        sb.push_back('{20'sd458738, FS16});
        sb.push_back('{FS16, FS16});
        for (int s = 0; s < 3; s++) begin
            run_sample(gi, gq, lat, rdy_ok);
            e = sb.pop_front();
            checks++;
            if (gi !== e.i || gq !== e.q) begin
                failures++;
                $display("FAIL freq_value[%0d] got I=%0d Q=%0d want I=%0d Q=%0d", s, gi, gq, e.i, e.q);
            end
        end
    endtask

    task automatic test_omega();
        logic signed [OUT_W-1:0] gi, gq;
        int lat; bit rdy_ok; exp_t e;
        do_reset();
        omega_n_add = 14'h1000;
        sb.push_back('{FS16, FS16});
        sb.push_back('{20'sd0, 20'sd0});
        sb.push_back('{-FS16, -FS16});
        sb.push_back('{20'sd0, 20'sd0});
        sb.push_back('{FS16, FS16});
        for (int s = 0; s < 5; s++) begin
            run_sample(gi, gq, lat, rdy_ok);
            e = sb.pop_front();
            checks++;
            if (gi !== e.i || gq !== e.q) begin
                failures++;
                $display("FAIL omega_value[%0d] got I=%0d Q=%0d want I=%0d Q=%0d", s, gi, gq, e.i, e.q);
            end
        end
        omega_n_add = '0;
    endtask

    task automatic test_gain_shift();
        logic signed [OUT_W-1:0] gi, gq;
        int lat; bit rdy_ok; exp_t e;
        do_reset();
        gain_shift = 4'd4;
        omega_n_add = 14'h2000;      // second sample sees every phase at half
        sb.push_back('{20'sd32767, 20'sd32767});
        sb.push_back('{-20'sd32767, -20'sd32767});
        for (int s = 0; s < 2; s++) begin
            run_sample(gi, gq, lat, rdy_ok);
            e = sb.pop_front();
            checks++;
            if (gi !== e.i || gq !== e.q) begin
                failures++;
                $display("FAIL gain_value[%0d] got I=%0d Q=%0d want I=%0d Q=%0d", s, gi, gq, e.i, e.q);
            end
        end
        gain_shift = '0;
        omega_n_add = '0;
    endtask

    task automatic test_cfg_err();
        logic signed [OUT_W-1:0] gi, gq;
        int lat; bit rdy_ok; exp_t e; bit seen;
        do_reset();
        sb.push_back('{FS16, FS16});
        @(negedge clk_fs) req = 1'b1;
        @(posedge clk_fs);
        #1 req = 1'b0;
        repeat (3) @(posedge clk_fs);
        @(negedge clk_fs);
        cfg_we = 1'b1; cfg_q = 1'b0; cfg_idx = 4'd0; cfg_freq = 14'h2000;
        @(posedge clk_fs);
        #1;
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL cfg_err_pulse got %b want 1", cfg_err);
        end
        @(negedge clk_fs) cfg_we = 1'b0;
        @(posedge clk_fs);
        #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_single got %b want 0", cfg_err);
        end
        seen = 1'b0; gi = '0; gq = '0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(posedge clk_fs);
            #1;
            if (out_valid) begin seen = 1'b1; gi = gauss_I; gq = gauss_Q; end
        end
        e = sb.pop_front();
        checks++;
        if (!seen || gi !== e.i || gq !== e.q) begin
            failures++;
            $display("FAIL cfg_run_sample got valid=%b I=%0d Q=%0d want 1 I=%0d Q=%0d", seen, gi, gq, e.i, e.q);
        end
        // Dropped write must not have changed the table.
        sb.push_back('{FS16, FS16});
        run_sample(gi, gq, lat, rdy_ok);
        e = sb.pop_front();
        checks++;
        if (gi !== e.i || gq !== e.q) begin
            failures++;
            $display("FAIL cfg_dropped got I=%0d Q=%0d want I=%0d Q=%0d", gi, gq, e.i, e.q);
        end
        // Same write in IDLE: tone 0 steps by half a period per sample.
        cfg_write(1'b0, 4'd0, 14'h2000);
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL cfg_idle_err got %b want 0", cfg_err);
        end
        sb.push_back('{FS16, FS16});
        sb.push_back('{20'sd458738, FS16});
        for (int s = 0; s < 2; s++) begin
            run_sample(gi, gq, lat, rdy_ok);
            e = sb.pop_front();
            checks++;
            if (gi !== e.i || gq !== e.q) begin
                failures++;
                $display("FAIL cfg_idle_value[%0d] got I=%0d Q=%0d want I=%0d Q=%0d", s, gi, gq, e.i, e.q);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic signed [OUT_W-1:0] gi, gq;
        int lat; bit rdy_ok; exp_t e; int pulses;
        do_reset();
        omega_n_add = 14'h1000;      // leave phases non-zero
        run_sample(gi, gq, lat, rdy_ok);
        @(negedge clk_fs) req = 1'b1;
        @(posedge clk_fs);
        #1 req = 1'b0;
        repeat (7) @(posedge clk_fs);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (gauss_I !== 0 || gauss_Q !== 0 || req_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got I=%0d Q=%0d ready=%b valid=%b want 0 0 1 0",
                     gauss_I, gauss_Q, req_ready, out_valid);
        end
        @(negedge clk_fs) rst = 1'b0;
        omega_n_add = '0;
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk_fs);
            #1;
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL abort_no_valid got %0d pulses want 0", pulses);
        end
        sb.push_back('{FS16, FS16});
        run_sample(gi, gq, lat, rdy_ok);
        e = sb.pop_front();
        checks++;
        if (gi !== e.i || gq !== e.q || lat !== 18) begin
            failures++;
            $display("FAIL abort_next got I=%0d Q=%0d lat=%0d want I=%0d Q=%0d lat=18", gi, gq, lat, e.i, e.q);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk_fs);
        test_reset();
        test_back_to_back();
        test_freq_table();
        test_omega();
        test_gain_shift();
        test_cfg_err();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
